// File: rtl/uart_tx_fifo_if.sv
// Byte handshake into uart_tx_fifo: the producer drives data/valid and the FIFO answers with ready.
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with an elastic byte FIFO; frames go back-to-back while bytes are queued.
// Define UART_TX_CTS_EN to gate frame starts on a synchronized, active-low cts_n.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_tx_fifo_if.slave          tx,
  input  logic                   cts_n,
  output logic                   UART_RXD_OUT,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;
  logic          push, pop, gate_open, bit_done, have_byte;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  // Resetting to 1 keeps the gate closed until the host actively asserts CTS.
  always_ff @(posedge clk) begin
    if (!rst_n) cts_sync_q <= 2'b11;
    else        cts_sync_q <= {cts_sync_q[0], cts_n};
  end
  assign gate_open = ~cts_sync_q[1];
`else
  logic unused_cts_n;
  assign unused_cts_n = cts_n;
  assign gate_open    = 1'b1;
`endif

  assign tx.tx_ready = (count_q != FULL);
  assign push        = tx.tx_valid && tx.tx_ready;
  assign bit_done    = (baud_q == BAUD_LAST);
  assign have_byte   = (count_q != '0) && gate_open;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (have_byte) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: if (bit_done) begin
        baud_d    = '0;
        bit_idx_d = '0;
        state_d   = S_DATA;
      end
      S_DATA: if (bit_done) begin
        baud_d    = '0;
        shift_d   = {1'b0, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 1'b1;
        if (bit_idx_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (bit_done) begin
        baud_d = '0;
        // Chain straight into the next start bit so queued frames leave no idle gap.
        if (have_byte) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line register follows the state one cycle later, so every bit keeps its full width.
  always_comb begin
    case (state_q)
      S_START: line_d = 1'b0;
      S_DATA:  line_d = shift_q[0];
      default: line_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      line_q    <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: storage has no reset; clearing the pointers and count already discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx.tx_data;
  end

  assign UART_RXD_OUT = line_q;
  assign busy         = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count   = count_q;
endmodule
